// File: rtl/s_box.sv
// s_box: registered PRESENT 4-bit S-box layer applied to every nibble of a
// W = 4*NIBBLES bit word. One cycle of latency, one word per cycle, no stall.
// Optional feature macro: SBOX_INVERSE_EN adds the inv_sel input, which
// selects the inverse table per word. The default build is forward-only.
//
// Handshake: a word is accepted on any rising edge where in_valid=1. The
// result is on substituted with out_valid=1 after that edge. There is no
// ready signal, so the producer is never stalled. When in_valid=0 the data
// register holds and out_valid falls. Consumers must qualify data with
// out_valid, because the reset value 0 is not S(0).
module s_box #(
    parameter int NIBBLES = 1
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   in_valid,
`ifdef SBOX_INVERSE_EN
    input  logic                   inv_sel,
`endif
    input  logic [4*NIBBLES-1:0]   orig,
    output logic                   out_valid,
    output logic [4*NIBBLES-1:0]   substituted
);

    localparam int W = 4 * NIBBLES;

    logic [W-1:0] substituted_q;
    logic [W-1:0] substituted_d;
    logic         out_valid_q;
    logic         out_valid_d;

    // Forward PRESENT S-box: 0..F -> C 5 6 B 9 0 A D 3 E F 8 4 7 1 2.
    function automatic logic [3:0] sbox_fwd(input logic [3:0] x);
        logic [3:0] y;
        case (x)
            4'h0: y = 4'hC;
            4'h1: y = 4'h5;
            4'h2: y = 4'h6;
            4'h3: y = 4'hB;
            4'h4: y = 4'h9;
            4'h5: y = 4'h0;
            4'h6: y = 4'hA;
            4'h7: y = 4'hD;
            4'h8: y = 4'h3;
            4'h9: y = 4'hE;
            4'hA: y = 4'hF;
            4'hB: y = 4'h8;
            4'hC: y = 4'h4;
            4'hD: y = 4'h7;
            4'hE: y = 4'h1;
            default: y = 4'h2;
        endcase
        return y;
    endfunction

`ifdef SBOX_INVERSE_EN
    // Inverse PRESENT S-box: 0..F -> 5 E F 8 C 1 2 D B 4 6 3 0 7 9 A.
    function automatic logic [3:0] sbox_inv(input logic [3:0] x);
        logic [3:0] y;
        case (x)
            4'h0: y = 4'h5;
            4'h1: y = 4'hE;
            4'h2: y = 4'hF;
            4'h3: y = 4'h8;
            4'h4: y = 4'hC;
            4'h5: y = 4'h1;
            4'h6: y = 4'h2;
            4'h7: y = 4'hD;
            4'h8: y = 4'hB;
            4'h9: y = 4'h4;
            4'hA: y = 4'h6;
            4'hB: y = 4'h3;
            4'hC: y = 4'h0;
            4'hD: y = 4'h7;
            4'hE: y = 4'h9;
            default: y = 4'hA;
        endcase
        return y;
    endfunction
`endif

    // Next state: substitute every nibble on an accepted word, otherwise hold
    // (orig is not looked at, so X/Z on an idle bus cannot leak in).
    always_comb begin
        substituted_d = substituted_q;
        out_valid_d   = in_valid;
        if (in_valid) begin
            for (int k = 0; k < NIBBLES; k++) begin
`ifdef SBOX_INVERSE_EN
                if (inv_sel) begin
                    substituted_d[4*k +: 4] = sbox_inv(orig[4*k +: 4]);
                end else begin
                    substituted_d[4*k +: 4] = sbox_fwd(orig[4*k +: 4]);
                end
`else
                substituted_d[4*k +: 4] = sbox_fwd(orig[4*k +: 4]);
`endif
            end
        end
    end

    // Output register with asynchronous clear; reset drops any in-flight word.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            substituted_q <= '0;
            out_valid_q   <= 1'b0;
        end else begin
            substituted_q <= substituted_d;
            out_valid_q   <= out_valid_d;
        end
    end

    assign substituted = substituted_q;
    assign out_valid   = out_valid_q;

endmodule

// File: tb/tb_s_box.sv
// tb_s_box: directed vectors for s_box, one 1-nibble and one 16-nibble instance.
module tb_s_box;

  logic        clk;
  logic        rst_n;
  logic        in_valid;
  logic [3:0]  orig_n;
  logic [63:0] orig_w;
  logic        out_valid_n;
  logic        out_valid_w;
  logic [3:0]  sub_n;
  logic [63:0] sub_w;
`ifdef SBOX_INVERSE_EN
  logic        inv_sel;
`endif

  int n_vec;
  int n_err;

  // hand-written PRESENT forward table
  logic [3:0] fwd_tab [0:15] = '{4'hC, 4'h5, 4'h6, 4'hB, 4'h9, 4'h0, 4'hA, 4'hD,
                                 4'h3, 4'hE, 4'hF, 4'h8, 4'h4, 4'h7, 4'h1, 4'h2};

  s_box #(.NIBBLES(1)) dut_n (
    .clk         (clk),
    .rst_n       (rst_n),
    .in_valid    (in_valid),
`ifdef SBOX_INVERSE_EN
    .inv_sel     (inv_sel),
`endif
    .orig        (orig_n),
    .out_valid   (out_valid_n),
    .substituted (sub_n)
  );

  s_box #(.NIBBLES(16)) dut_w (
    .clk         (clk),
    .rst_n       (rst_n),
    .in_valid    (in_valid),
`ifdef SBOX_INVERSE_EN
    .inv_sel     (inv_sel),
`endif
    .orig        (orig_w),
    .out_valid   (out_valid_w),
    .substituted (sub_w)
  );

  // clock / reset
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // drive one word at the falling edge, sample 1 time unit after the capture edge
  task automatic drive(input logic v, input logic [3:0] dn, input logic [63:0] dw);
    @(negedge clk);
    in_valid = v;
    orig_n   = dn;
    orig_w   = dw;
    @(posedge clk);
    #1;
  endtask

  logic [3:0] tmp;

  initial begin
    n_vec    = 0;
    n_err    = 0;
    rst_n    = 1'b0;
    in_valid = 1'b1;
    orig_n   = 4'hF;
    orig_w   = '1;
`ifdef SBOX_INVERSE_EN
    inv_sel  = 1'b0;
`endif

    // reset held across edges with valid input
    repeat (3) @(posedge clk);
    #1;
    check("rst_data", {60'd0, sub_n}, 64'd0);
    check("rst_valid", {63'd0, out_valid_n}, 64'd0);
    check("rst_data_w", sub_w, 64'd0);
    @(negedge clk);
    rst_n = 1'b1;

    // exhaustive forward, back to back
    for (int k = 0; k < 16; k++) begin
      tmp = 4'(k);
      drive(1'b1, tmp, 64'd0);
      check($sformatf("fwd_%0h", k), {60'd0, sub_n}, {60'd0, fwd_tab[k]});
      check($sformatf("fwd_v_%0h", k), {63'd0, out_valid_n}, 64'd1);
    end

    // spot checks against literal expectations
    drive(1'b1, 4'h0, 64'd0);
    check("spot_0", {60'd0, sub_n}, 64'hC);
    drive(1'b1, 4'h1, 64'd0);
    check("spot_1", {60'd0, sub_n}, 64'h5);
    drive(1'b1, 4'h2, 64'd0);
    check("spot_2", {60'd0, sub_n}, 64'h6);
    drive(1'b1, 4'hF, 64'd0);
    check("spot_F", {60'd0, sub_n}, 64'h2);

    // hold when idle
    drive(1'b1, 4'h3, 64'd0);
    check("hold_cap", {60'd0, sub_n}, 64'hB);
    check("hold_cap_v", {63'd0, out_valid_n}, 64'd1);
    drive(1'b0, 4'h7, 64'd0);
    check("hold_data", {60'd0, sub_n}, 64'hB);
    check("hold_v", {63'd0, out_valid_n}, 64'd0);
    drive(1'b0, 4'bxxxx, {64{1'bx}});
    check("hold_x", {60'd0, sub_n}, 64'hB);
    check("hold_x_v", {63'd0, out_valid_n}, 64'd0);

    // multi-nibble words
    drive(1'b1, 4'h0, 64'h0123456789ABCDEF);
    check("wide_a", sub_w, 64'hC56B90AD3EF84712);
    check("wide_a_v", {63'd0, out_valid_w}, 64'd1);
    drive(1'b1, 4'h0, 64'hFEDCBA9876543210);
    check("wide_b", sub_w, 64'h21748FE3DA09B65C);

    // asynchronous reset between edges
    drive(1'b1, 4'h9, 64'h0);
    check("pre_async", {60'd0, sub_n}, 64'hE);
    #2;
    rst_n = 1'b0;
    #1;
    check("async_data", {60'd0, sub_n}, 64'd0);
    check("async_v", {63'd0, out_valid_n}, 64'd0);
    check("async_data_w", sub_w, 64'd0);
    @(negedge clk);
    rst_n = 1'b1;

    // mid-stream reset: word 1 is discarded
    drive(1'b1, 4'h0, 64'd0);
    check("mid_w0", {60'd0, sub_n}, 64'hC);
    @(negedge clk);
    in_valid = 1'b1;
    orig_n   = 4'h1;
    #2;
    rst_n = 1'b0;
    #1;
    check("mid_rst_data", {60'd0, sub_n}, 64'd0);
    check("mid_rst_v", {63'd0, out_valid_n}, 64'd0);
    @(posedge clk);
    #1;
    check("mid_discard", {60'd0, sub_n}, 64'd0);
    check("mid_discard_v", {63'd0, out_valid_n}, 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    drive(1'b1, 4'hF, 64'd0);
    check("mid_after", {60'd0, sub_n}, 64'h2);
    check("mid_after_v", {63'd0, out_valid_n}, 64'd1);

`ifdef SBOX_INVERSE_EN
    inv_sel = 1'b1;
    drive(1'b1, 4'hC, 64'd0);
    check("inv_C", {60'd0, sub_n}, 64'h0);
    drive(1'b1, 4'h2, 64'd0);
    check("inv_2", {60'd0, sub_n}, 64'hF);
    drive(1'b1, 4'h0, 64'hC56B90AD3EF84712);
    check("inv_wide", sub_w, 64'h0123456789ABCDEF);
    for (int k = 0; k < 16; k++) begin
      inv_sel = 1'b0;
      tmp = 4'(k);
      drive(1'b1, tmp, 64'd0);
      tmp = sub_n;
      inv_sel = 1'b1;
      drive(1'b1, tmp, 64'd0);
      check($sformatf("round_%0h", k), {60'd0, sub_n}, 64'(k));
    end
    inv_sel = 1'b0;
`endif

    @(negedge clk);
    in_valid = 1'b0;
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
